// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word input, LSB-first serial
// output with a one-word holding buffer so that back-to-back words go out with no gap.
module piso_tx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data_in,
  input  logic                  p_data_in_val,
  input  logic                  p_data_in_last,
  output logic                  p_data_in_rdy,
  input  logic                  piso_cancel,
  output logic                  s_data_out,
  output logic                  s_data_out_val,
  output logic                  s_data_out_last,
  output logic                  busy
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  hold_last_q, hold_last_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  cur_last_q, cur_last_d;
  logic                  s_data_q, s_data_d;
  logic                  s_val_q, s_val_d;
  logic                  s_last_q, s_last_d;
  logic                  load;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      hold_last_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      cur_last_q  <= 1'b0;
      s_data_q    <= 1'b0;
      s_val_q     <= 1'b0;
      s_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      hold_last_q <= hold_last_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      cur_last_q  <= cur_last_d;
      s_data_q    <= s_data_d;
      s_val_q     <= s_val_d;
      s_last_q    <= s_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    hold_last_d = hold_last_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    cur_last_d  = cur_last_q;
    s_data_d    = s_data_q;
    s_val_d     = s_val_q;
    s_last_d    = s_last_q;
    load        = 1'b0;

    if (piso_cancel) begin
      state_d     = IDLE;
      hold_d      = '0;
      hold_full_d = 1'b0;
      hold_last_d = 1'b0;
      shift_d     = '0;
      bit_cnt_d   = '0;
      cur_last_d  = 1'b0;
      s_data_d    = 1'b0;
      s_val_d     = 1'b0;
      s_last_d    = 1'b0;
    end else begin
      // Accept and load never coincide: accepting requires an empty hold buffer.
      if (p_data_in_val && !hold_full_q) begin
        hold_d      = p_data_in;
        hold_last_d = p_data_in_last;
        hold_full_d = 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            s_data_d = 1'b0;
            s_val_d  = 1'b0;
            s_last_d = 1'b0;
          end
        end
        SHIFT: begin
          if (bit_cnt_q != LAST_BIT) begin
            s_data_d  = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            s_last_d  = cur_last_q && ((bit_cnt_q + CNT_W'(1)) == LAST_BIT);
          end else if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            s_data_d  = 1'b0;
            s_val_d   = 1'b0;
            s_last_d  = 1'b0;
          end
        end
      endcase

      if (load) begin
        state_d     = SHIFT;
        s_data_d    = hold_q[0];
        shift_d     = hold_q >> 1;
        bit_cnt_d   = '0;
        s_val_d     = 1'b1;
        s_last_d    = 1'b0;
        cur_last_d  = hold_last_q;
        hold_full_d = 1'b0;
      end
    end
  end

  always_comb begin
    p_data_in_rdy   = !hold_full_q && !piso_cancel;
    busy            = (state_q == SHIFT) || hold_full_q;
    s_data_out      = s_data_q;
    s_data_out_val  = s_val_q;
    s_data_out_last = s_last_q;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in serial-out transmitter. It is the transmit-side counterpart of the hub's serial-to-parallel receive path.
- Accepts DATA_WIDTH-bit words over a valid/ready handshake and emits them LSB first, one bit per clk, with a bit-valid qualifier.
- A one-word holding buffer in front of the shift register allows gapless back-to-back words.
- Sits between the packet/byte source and the line-encoding stage.

Parameters:
- DATA_WIDTH, 8, bits per parallel word; legal range 2..32.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-low: 0 = reset.
- p_data_in  input  DATA_WIDTH  parallel word to transmit.
- p_data_in_val  input  1  p_data_in is valid.
- p_data_in_last  input  1  word is the final word of a packet; qualified by p_data_in_val.
- p_data_in_rdy  output  1  block can accept a word; combinational: !hold_full && !piso_cancel.
- piso_cancel  input  1  synchronous abort/flush, active-high.
- s_data_out  output  1  serial bit; 0 whenever s_data_out_val = 0.
- s_data_out_val  output  1  s_data_out carries a valid bit this cycle.
- s_data_out_last  output  1  high only on the final bit of a last-flagged word.
- busy  output  1  state == SHIFT or hold_full.

Behaviour:
- Reset (rst = 0 at an edge): s_data_out, s_data_out_val, s_data_out_last = 0. Hold buffer, shift register, bit counter, hold_full and hold_last are cleared. State = IDLE. p_data_in_rdy is 1 in the cycle after reset is released.
- Cancel (rst = 1, piso_cancel = 1): same clearing as reset. p_data_in_rdy = 0 that cycle, so no word is accepted. Priority order: rst, then piso_cancel, then normal operation.
- Accept: at an edge where p_data_in_val && p_data_in_rdy, p_data_in and p_data_in_last are latched into the hold buffer and hold_full is set. p_data_in is a don't-care when val = 0.
- Bit counter: width $clog2(DATA_WIDTH). Counts 0..DATA_WIDTH-1 and never wraps silently; it is reloaded to 0 on every word load.
- State machine (two states, IDLE and SHIFT):
  - IDLE: if hold_full, perform a load at that edge and go to SHIFT; otherwise outputs stay 0.
  - Load: s_data_out <= hold[0]; shift_reg <= hold >> 1; bit_cnt <= 0; s_data_out_val <= 1; cur_last <= hold_last; hold_full <= 0.
  - SHIFT with bit_cnt < DATA_WIDTH-1: s_data_out <= shift_reg[0]; shift_reg shifts right; bit_cnt++.
  - SHIFT with bit_cnt == DATA_WIDTH-1 (final bit currently driven), hold_full = 1: load at this edge and stay in SHIFT. This gives a gapless stream.
  - SHIFT with bit_cnt == DATA_WIDTH-1, hold_full = 0: outputs go to 0, state goes to IDLE.
- s_data_out_last is a registered output. It is 1 exactly while bit DATA_WIDTH-1 of a word with cur_last = 1 is being driven.
- Latency: word accepted at edge T, so hold_full = 1 after T. The load happens at edge T+1, so bit 0 is driven in the cycle after T+1, and bits 1..DATA_WIDTH-1 follow on consecutive cycles.
- Throughput: one word per DATA_WIDTH cycles when the source keeps val high. rdy reasserts the cycle after each load, so the next word can be staged while the current one shifts.
- Underrun: if no word is staged when a word finishes, s_data_out_val drops for at least one cycle. The block never repeats or invents bits.
- Simultaneous accept and load at the same edge is impossible by construction, because rdy requires hold_full = 0.
- Reset or cancel mid-word discards the partial word and any staged word, with no further valid bits. The first word after release follows normal latency.

Test Plan:
1. Reset: rst = 0 for 3 cycles with p_data_in_val = 1 -> all outputs 0, nothing latched. After release: rdy = 1, val = 0, busy = 0.
2. Single word (DATA_WIDTH = 8): 8'hA5 accepted at edge T -> from the cycle after T+1, s_data_out = 1,0,1,0,0,1,0,1 with val = 1 for exactly 8 cycles, then val = 0 and busy = 0.
3. Back-to-back: 8'h01 then 8'h80 with val held high -> 16 contiguous val = 1 cycles, bits 1,0×7,0×7,1. rdy is low only in the cycle each word sits staged before its load.
4. Last flag: 8'h3C with last = 1, then 8'hC3 with last = 0 -> s_data_out_last = 1 only on cycle 8 of the first word; 0 elsewhere.
5. Cancel: 8'hFF in flight and 8'h55 staged, piso_cancel pulsed at bit 3 -> val = 0 from the next cycle, 8'h55 is never sent. A fresh 8'h0F is then sent cleanly as 1,1,1,1,0,0,0,0.
6. Underrun: second word 8'hAA offered 3 cycles after the first word ends -> val gap of at least 4 cycles, then 8 correct bits 0,1,0,1,0,1,0,1.
